program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Host-side driver of the CPU programmer interface (p_programm/p_data/p_address/p_write_en_mem/p_active).
//  Accepts a nibble stream from a host via valid/ready, requests programming mode, writes words to
//  memory starting at address 0, checks a mod-2^W checksum, then releases the CPU to run from PC=0.
// PARAMETERS
//  REGISTER_WIDTH        4  data word width (W); also checksum width
//  MEMORY_ADDRESS_WIDTH  4  address width (A); max program length 2^A words
// PORTS
//  clk_i             in   1  system clock
//  reset_ni          in   1  asynchronous, active-low reset
//  start_i           in   1  begin a load; one-cycle pulse, honoured only in IDLE or ERROR
//  host_valid_i      in   1  host nibble valid
//  host_data_i       in   W  host nibble
//  host_ready_o      out  1  loader accepts nibble this cycle (transfer = valid & ready)
//  p_programm_o      out  1  request/hold CPU in programming mode
//  p_active_i        in   1  CPU acknowledges programming mode
//  p_address_o       out  A  memory write address
//  p_data_o          out  W  memory write data
//  p_write_en_mem_o  out  1  memory write strobe, one cycle per word
//  busy_o            out  1  high in any state except IDLE
//  done_o            out  1  one-cycle pulse: load verified and CPU released
//  error_o           out  1  checksum mismatch or lost p_active_i; cleared by next accepted start_i
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/checksum 0. Reset mid-load aborts; no write is issued.
//  Stream format: LEN (=N-1, N in 1..2^A), then N data nibbles, then CSUM = sum(data) mod 2^W.
//  States / transitions:
//   IDLE     : start_i -> WAIT_ACT; p_programm_o<=1, error_o<=0.
//   WAIT_ACT : hold p_programm_o; p_active_i=1 -> GET_LEN. CPU acks only at instruction end; no timeout.
//   GET_LEN  : host_ready_o=1; on transfer store remaining=LEN+1 (A+1 bits), addr=0, sum=0 -> GET_DATA.
//   GET_DATA : host_ready_o=1; on transfer register data into p_data_o, sum<=sum+data (wraps) -> WRITE.
//   WRITE    : p_write_en_mem_o=1 exactly one cycle, p_address_o=addr; host_ready_o=0;
//              addr<=addr+1 (wraps at 2^A), remaining<=remaining-1; remaining==1 -> GET_CSUM else GET_DATA.
//   GET_CSUM : host_ready_o=1; on transfer: equal -> RELEASE (p_programm_o<=0); unequal -> ERROR.
//   RELEASE  : p_programm_o=0; wait p_active_i=0 -> IDLE with done_o=1 for that one cycle.
//   ERROR    : error_o=1, p_programm_o held 1 (CPU stays halted, memory still unlocked);
//              start_i -> GET_LEN if p_active_i=1, else WAIT_ACT; error_o cleared on that start_i.
//  Throughput: one data word per 2 cycles; latency LEN transfer -> first write >= 2 cycles.
//  p_address_o/p_data_o hold their last value outside WRITE; only the strobe qualifies them.
//  p_active_i falling in GET_LEN/GET_DATA/WRITE/GET_CSUM -> ERROR (error_o=1); no further writes.
//  p_write_en_mem_o is never asserted unless p_active_i=1 in the same cycle.
//  start_i in any busy state other than ERROR is ignored. host_valid_i outside ready states is ignored.
//  N=2^A (LEN all ones) writes every address once; addr wraps to 0, no extra write.
// STRUCTURE
//  Shared package/include: loader state encodings, LOADER_CSUM_W (=REGISTER_WIDTH).
//  Single module; checksum accumulator and word counter inline; no sub-module.
// TESTING
//  1 Load LEN=2, data 3,A,5, CSUM=2 -> writes (0,3),(1,A),(2,5), p_programm_o falls, done_o pulse.
//  2 Same stream with CSUM=7 -> no release, error_o=1, p_programm_o stays 1; resend stream after start_i -> done_o.
//  3 LEN=F, 16 nibbles 0..F, CSUM=8 -> 16 writes addr 0..F, no 17th write, done_o.
//  4 p_active_i delayed 5 cycles after start_i -> host_ready_o low until ack; no write before ack.
//  5 Drop p_active_i after second write -> error_o=1, no further p_write_en_mem_o.
//  6 Assert reset_ni=0 during GET_DATA -> all outputs 0 immediately; start_i restarts cleanly.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths and state encoding for the program loader
package program_loader_pkg;
  localparam int LOADER_W      = 4;
  localparam int LOADER_A      = 4;
  localparam int LOADER_CSUM_W = LOADER_W;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACT, S_GET_LEN, S_GET_DATA, S_WRITE, S_GET_CSUM, S_RELEASE, S_ERROR
  } loader_state_e;
endpackage

// File: rtl/program_loader.sv
// program_loader: host nibble stream -> CPU program memory writer with checksum and CPU hand-off
// ports: clk_i/reset_ni clock and async active-low reset; start_i load request;
//        host_valid_i/host_data_i/host_ready_o host nibble handshake;
//        p_programm_o/p_active_i programming-mode request and CPU ack;
//        p_address_o/p_data_o/p_write_en_mem_o memory write port;
//        busy_o not idle, done_o one-cycle success pulse, error_o checksum or ack-loss fault
module program_loader
  import program_loader_pkg::*;
#(
  parameter int REGISTER_WIDTH       = LOADER_CSUM_W,
  parameter int MEMORY_ADDRESS_WIDTH = LOADER_A
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            start_i,
  input  logic                            host_valid_i,
  input  logic [REGISTER_WIDTH-1:0]       host_data_i,
  output logic                            host_ready_o,
  output logic                            p_programm_o,
  input  logic                            p_active_i,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
  output logic [REGISTER_WIDTH-1:0]       p_data_o,
  output logic                            p_write_en_mem_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o
);
  localparam int W = REGISTER_WIDTH;
  localparam int A = MEMORY_ADDRESS_WIDTH;
  loader_state_e state_q, state_d;
  logic [A:0]   rem_q, rem_d;
  logic [A-1:0] addr_q, addr_d;
  logic [W-1:0] data_q, data_d, sum_q, sum_d;
  logic         done_q, done_d;
  logic         xfer;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  // ready is gated by the ack so a nibble is never swallowed in the cycle the CPU drops out
  assign host_ready_o     = p_active_i && (state_q == S_GET_LEN || state_q == S_GET_DATA || state_q == S_GET_CSUM);
  assign xfer             = host_valid_i && host_ready_o;
  assign p_programm_o     = !(state_q == S_IDLE || state_q == S_RELEASE);
  assign p_write_en_mem_o = (state_q == S_WRITE) && p_active_i;
  assign p_address_o      = addr_q;
  assign p_data_o         = data_q;
  assign busy_o           = state_q != S_IDLE;
  assign done_o           = done_q;
  assign error_o          = state_q == S_ERROR;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:     state_d = start_i ? S_WAIT_ACT : S_IDLE;
      S_WAIT_ACT: state_d = p_active_i ? S_GET_LEN : S_WAIT_ACT;
      S_GET_LEN:
        if (!p_active_i) state_d = S_ERROR;
        else if (xfer) begin
          rem_d   = (A+1)'(host_data_i) + (A+1)'(1);
          addr_d  = '0;
          sum_d   = '0;
          state_d = S_GET_DATA;
        end
      S_GET_DATA:
        if (!p_active_i) state_d = S_ERROR;
        else if (xfer) begin
          data_d  = host_data_i;
          sum_d   = sum_q + host_data_i;
          state_d = S_WRITE;
        end
      S_WRITE:
        if (!p_active_i) state_d = S_ERROR;
        else begin
          addr_d  = addr_q + A'(1);
          rem_d   = rem_q - (A+1)'(1);
          state_d = (rem_q == (A+1)'(1)) ? S_GET_CSUM : S_GET_DATA;
        end
      S_GET_CSUM:
        if (!p_active_i) state_d = S_ERROR;
        else if (xfer) state_d = (host_data_i == sum_q) ? S_RELEASE : S_ERROR;
      S_RELEASE:
        if (!p_active_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      S_ERROR:    state_d = start_i ? (p_active_i ? S_GET_LEN : S_WAIT_ACT) : S_ERROR;
      default:    state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader with a simple CPU ack model
module tb_program_loader;
  typedef struct packed {logic [1:0] k; logic [3:0] a; logic [3:0] d;} ev_t;
  localparam logic [1:0] K_WR = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;
  logic clk = 0, reset_ni = 0, start = 0, hv = 0, act_q = 0, kill = 0;
  logic [3:0] hd = 0;
  wire p_active = act_q & ~kill;
  logic host_ready, p_programm, p_we, busy, done, error;
  logic [3:0] p_addr, p_data;
  int tests = 0, fails = 0, nwr = 0, ack_dly = 0, cnt = 0;
  ev_t q[$];
  logic err_prev = 0;
  program_loader dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .host_valid_i(hv), .host_data_i(hd),
    .host_ready_o(host_ready), .p_programm_o(p_programm), .p_active_i(p_active),
    .p_address_o(p_addr), .p_data_o(p_data), .p_write_en_mem_o(p_we),
    .busy_o(busy), .done_o(done), .error_o(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!p_programm) begin
      act_q <= 0;
      cnt   <= 0;
    end else if (cnt >= ack_dly) act_q <= 1;
    else cnt <= cnt + 1;
  task automatic chk(input string nm, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  function automatic ev_t mk(input logic [1:0] k, input int a, input logic [3:0] d);
    return {k, 4'(a), d};
  endfunction
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (reset_ni) begin
      if (p_we) begin
        nwr++;
        chk("we_needs_active", p_active, 1);
        if (q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = q.pop_front();
          chk("write_kind", e.k, K_WR);
          chk("write_addr", p_addr, e.a);
          chk("write_data", p_data, e.d);
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_kind", K_DONE, e.k);
        end
      end
      if (error && !err_prev) begin
        if (q.size() == 0) chk("unexpected_error", 1, 0);
        else begin
          e = q.pop_front();
          chk("error_kind", K_ERR, e.k);
        end
      end
    end
    err_prev = error;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(input logic [3:0] d);
    int n = 0;
    hv = 1;
    hd = d;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ready && n < 100);
    if (!host_ready) chk("send_timeout", 0, 1);
    tick();
    hv = 0;
  endtask
  task automatic load(input logic [3:0] len, input logic [3:0] d[16], input logic [3:0] cs, input bit ok);
    send(len);
    for (int i = 0; i <= int'(len); i++) begin
      q.push_back(mk(K_WR, i, d[i]));
      send(d[i]);
    end
    q.push_back(mk(ok ? K_DONE : K_ERR, 0, 0));
    send(cs);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    chk("reach_idle", busy, 0);
    tick();
  endtask
  task automatic wait_err();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!error && n < 50);
    chk("reach_error", error, 1);
    tick();
  endtask
  task automatic wait_writes(input int target);
    int n = 0;
    while (nwr < target && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("write_count", nwr, target);
    #1;
  endtask
  initial begin
    logic [3:0] v1[16], v3[16];
    int base;
    v1 = '{default: 4'h0};
    v1[0] = 4'h3; v1[1] = 4'hA; v1[2] = 4'h5;
    for (int i = 0; i < 16; i++) v3[i] = 4'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_programm", p_programm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_addr", p_addr, 0);
    reset_ni = 1;
    tick();
    chk("idle_done", done, 0);
    chk("idle_error", error, 0);
    // 1: basic load
    pulse_start();
    chk("t1_programm", p_programm, 1);
    chk("t1_busy", busy, 1);
    load(4'h2, v1, 4'h2, 1);
    chk("t1_release_programm", p_programm, 0);
    wait_idle();
    // 2: bad checksum, then retry from ERROR
    pulse_start();
    load(4'h2, v1, 4'h7, 0);
    wait_err();
    chk("t2_error", error, 1);
    chk("t2_programm", p_programm, 1);
    repeat (3) tick();
    chk("t2_still_error", error, 1);
    pulse_start();
    chk("t2_error_cleared", error, 0);
    chk("t2_ready_after_start", host_ready, 1);
    load(4'h2, v1, 4'h2, 1);
    wait_idle();
    // 3: full-depth load, address wrap without extra write
    base = nwr;
    pulse_start();
    load(4'hF, v3, 4'h8, 1);
    wait_idle();
    chk("t3_writes", nwr - base, 16);
    chk("t3_addr_wrap", p_addr, 0);
    // 4: delayed CPU ack
    ack_dly = 5;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_ready_low", host_ready, 0);
      chk("t4_programm_hold", p_programm, 1);
    end
    tick();
    load(4'h2, v1, 4'h2, 1);
    wait_idle();
    ack_dly = 0;
    // 5: CPU drops ack after the second write
    base = nwr;
    pulse_start();
    send(4'h3);
    q.push_back(mk(K_WR, 0, 4'h1));
    send(4'h1);
    q.push_back(mk(K_WR, 1, 4'h2));
    send(4'h2);
    q.push_back(mk(K_ERR, 0, 0));
    wait_writes(base + 2);
    kill = 1;
    hv = 1;
    hd = 4'h3;
    repeat (4) tick();
    chk("t5_error", error, 1);
    chk("t5_programm", p_programm, 1);
    chk("t5_ready_low", host_ready, 0);
    chk("t5_no_more_writes", nwr - base, 2);
    hv = 0;
    kill = 0;
    tick();
    pulse_start();
    chk("t5_error_cleared", error, 0);
    load(4'h2, v1, 4'h2, 1);
    wait_idle();
    // 6: reset during GET_DATA
    base = nwr;
    pulse_start();
    send(4'h2);
    q.push_back(mk(K_WR, 0, 4'h3));
    send(4'h3);
    wait_writes(base + 1);
    reset_ni = 0;
    #1;
    chk("t6_programm", p_programm, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", p_data, 0);
    chk("t6_addr", p_addr, 0);
    chk("t6_we", p_we, 0);
    chk("t6_ready", host_ready, 0);
    chk("t6_error", error, 0);
    tick();
    reset_ni = 1;
    tick();
    pulse_start();
    load(4'h2, v1, 4'h2, 1);
    wait_idle();
    repeat (2) tick();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
